// File: rtl/mux3_arbiter.sv
// rtl/mux3_arbiter.sv - three-way round-robin arbiter with hold limit, drives select for mux3b1
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   req[2:0] level request lines, bit0=A, bit1=B, bit2=C
//   gnt[2:0] registered grant, zero or one-hot, same bit mapping as req
//   s[1:0]   registered mux select, 0=A 1=B 2=C; holds last owner while idle
//   busy     registered, high while a grant is outstanding
module mux3_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] s,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0] MAX_HOLD_V = 4'(MAX_HOLD);

    state_t     state;
    logic [1:0] last;
    logic [3:0] hold;

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic       owner_req;
    logic       others;
    logic       hold_full;

    function automatic logic [1:0] rr_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    return r[0];
            2'd1:    return r[1];
            2'd2:    return r[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Search order last+1, last+2, last. The current owner is always 'last',
    // so it lands at the end of the order: on release or preemption any other
    // pending requester wins before the owner could be picked again.
    always_comb begin
        cand0      = rr_inc(last);
        cand1      = rr_inc(cand0);
        cand2      = rr_inc(cand1);
        pick_valid = |req;
        pick_idx   = cand2;
        if (req_at(req, cand1)) begin
            pick_idx = cand1;
        end
        if (req_at(req, cand0)) begin
            pick_idx = cand0;
        end
    end

    always_comb begin
        owner_req = req_at(req, s);
        others    = |(req & ~gnt);
        hold_full = (hold >= MAX_HOLD_V);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt   <= 3'b000;
            s     <= 2'd0;
            busy  <= 1'b0;
            hold  <= 4'd0;
            last  <= 2'd2;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= OWN;
                        gnt   <= to_onehot(pick_idx);
                        s     <= pick_idx;
                        last  <= pick_idx;
                        busy  <= 1'b1;
                        hold  <= 4'd1;
                    end
                end
                OWN: begin
                    if (!owner_req || (hold_full && others)) begin
                        // Handover happens on the same edge as release, so
                        // there is never an idle bubble between owners.
                        if (pick_valid) begin
                            gnt  <= to_onehot(pick_idx);
                            s    <= pick_idx;
                            last <= pick_idx;
                            hold <= 4'd1;
                        end else begin
                            state <= IDLE;
                            gnt   <= 3'b000;
                            busy  <= 1'b0;
                        end
                    end else if (!hold_full) begin
                        hold <= hold + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 3'b000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux3_arbiter.sv
// tb/tb_mux3_arbiter.sv - randomized and directed bench for mux3_arbiter against a behavioural model
module tb_mux3_arbiter;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] req     = 3'b000;

    logic [2:0] gnt  [2];
    logic [1:0] s    [2];
    logic       busy [2];

    mux3_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt[0]),
        .s       (s[0]),
        .busy    (busy[0])
    );

    mux3_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt[1]),
        .s       (s[1]),
        .busy    (busy[1])
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int owner;
        int last;
        int hold;
        int s;
    } mstate_t;

    mstate_t m [2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mstate_t reset_state();
        mstate_t r;
        r.owner = -1;
        r.last  = 2;
        r.hold  = 0;
        r.s     = 0;
        return r;
    endfunction

    function automatic int rr_first(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t cur, input logic [2:0] r, input int maxhold);
        mstate_t n;
        int      pick;
        bit      others;
        n      = cur;
        pick   = rr_first(r, cur.last);
        others = 1'b0;
        if (cur.owner < 0) begin
            if (pick >= 0) begin
                n.owner = pick; n.last = pick; n.s = pick; n.hold = 1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i != cur.owner && r[i]) others = 1'b1;
            end
            if (!r[cur.owner] || (cur.hold >= maxhold && others)) begin
                if (pick >= 0) begin
                    n.owner = pick; n.last = pick; n.s = pick; n.hold = 1;
                end else begin
                    n.owner = -1;
                end
            end else if (cur.hold < maxhold) begin
                n.hold = cur.hold + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m[0] <= reset_state();
            m[1] <= reset_state();
        end else begin
            m[0] <= model_next(m[0], req, 4);
            m[1] <= model_next(m[1], req, 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int exp_g;
                exp_g = (m[k].owner < 0) ? 0 : (1 << m[k].owner);
                chk($sformatf("model_gnt%0d", k), int'(gnt[k]), exp_g);
                chk($sformatf("model_s%0d", k), int'(s[k]), m[k].s);
                chk($sformatf("model_busy%0d", k), int'(busy[k]), (m[k].owner >= 0) ? 1 : 0);
                chk($sformatf("onehot0_%0d", k), int'($onehot0(gnt[k])), 1);
                chk($sformatf("busy_or_%0d", k), int'(busy[k]), int'(|gnt[k]));
                if (gnt[k] != 3'b000) begin
                    chk($sformatf("s_match_%0d", k), int'(gnt[k]), 1 << s[k]);
                end
            end
        end
    end

    task automatic step(input logic [2:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] one;
        logic [2:0] r;
        one = 3'b001;

        #1 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_gnt", int'(gnt[0]), 0);
        chk("rst_s", int'(s[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);

        // all three requesting: A first, then 4-cycle rotation; MAX_HOLD=1 rotates every cycle
        for (int i = 0; i < 13; i++) begin
            step(3'b111);
            chk($sformatf("rot4_gnt_%0d", i), int'(gnt[0]), int'(one << ((i / 4) % 3)));
            chk($sformatf("rot4_s_%0d", i), int'(s[0]), (i / 4) % 3);
            chk($sformatf("rot1_gnt_%0d", i), int'(gnt[1]), int'(one << (i % 3)));
        end

        // B alone held: grant stays on B, saturating hold, no idle glitch
        for (int i = 0; i < 10; i++) begin
            step(3'b010);
            chk($sformatf("bonly_gnt_%0d", i), int'(gnt[0]), 2);
            chk($sformatf("bonly_s_%0d", i), int'(s[0]), 1);
        end

        // A owns, request drops from 101 to 100: direct handover to C
        step(3'b001);
        chk("a_own_gnt", int'(gnt[0]), 1);
        step(3'b101);
        chk("a_keep_gnt", int'(gnt[0]), 1);
        step(3'b100);
        chk("handover_gnt", int'(gnt[0]), 4);
        chk("handover_s", int'(s[0]), 2);
        chk("handover_busy", int'(busy[0]), 1);

        // C releases to idle, S holds 2, next search starts at A
        step(3'b000);
        chk("idle_gnt", int'(gnt[0]), 0);
        chk("idle_busy", int'(busy[0]), 0);
        chk("idle_s", int'(s[0]), 2);
        step(3'b011);
        chk("from_c_gnt", int'(gnt[0]), 1);

        // async reset mid-cycle while B owns
        step(3'b010);
        chk("pre_rst_gnt", int'(gnt[0]), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_gnt", int'(gnt[0]), 0);
        chk("async_s", int'(s[0]), 0);
        chk("async_busy", int'(busy[0]), 0);
        #2 reset_n = 1'b1;
        step(3'b110);
        chk("post_rst_gnt", int'(gnt[0]), 2);

        // randomized traffic, mostly held requests, rare async resets
        r = 3'b000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            step(r);
            if ($urandom_range(0, 149) == 0) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
